// File: rtl/control_decode_stage.sv
// control_decode_stage: registered RV32 main decoder with valid/ready flow control.
// Decodes one 32-bit instruction per accept into datapath controls and holds them
// for the execute stage. Illegal encodings become a no-op and are counted (saturating).
// Optional feature macro: CONTROL_DECODE_MULDIV_EN. When defined, R-type funct7=0000001
// decodes as an M-extension op that occupies the stage for MULDIV_LATENCY cycles.
module control_decode_stage #(
   parameter int INSTR_WIDTH       = 32,
   parameter int MULDIV_LATENCY    = 4,
   parameter int ILLEGAL_CNT_WIDTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [INSTR_WIDTH-1:0]       instr_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic                         ready_i,
   input  logic                         flush_i,
   output logic                         valid_o,
   output logic                         branch_o,
   output logic                         jump_o,
   output logic                         mem_write_o,
   output logic                         alu_src_o,
   output logic                         reg_write_o,
   output logic [1:0]                   result_src_o,
   output logic [2:0]                   imm_src_o,
   output logic [1:0]                   alu_op_o,
   output logic [4:0]                   rd_o,
   output logic                         muldiv_o,
   output logic                         illegal_o,
   output logic [ILLEGAL_CNT_WIDTH-1:0] illegal_cnt_o
);

   // Decoded control word; field order follows the decode table rows.
   typedef struct packed {
      logic       reg_write;
      logic [2:0] imm_src;
      logic       alu_src;
      logic       mem_write;
      logic [1:0] result_src;
      logic       branch;
      logic [1:0] alu_op;
      logic       jump;
      logic       muldiv;
      logic       illegal;
   } ctrl_t;

   // Illegal encodings: every control strobe low, only the illegal flag raised.
   localparam ctrl_t CTRL_ILLEGAL = 14'b00000000000001;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FULL    = 2'd1
`ifdef CONTROL_DECODE_MULDIV_EN
      ,MD_BUSY = 2'd2
`endif
   } state_t;

   // Opcode decode; M-extension recognition exists only in the muldiv build.
   function automatic ctrl_t decode(input logic [31:0] ins);
      ctrl_t c;
      c = CTRL_ILLEGAL;
      case (ins[6:0])
         7'b0000011: c = {12'b1_000_1_0_01_0_00_0, 2'b00};   // load
         7'b0100011: c = {12'b0_001_1_1_00_0_00_0, 2'b00};   // store
         7'b1100011: c = {12'b0_010_0_0_00_1_01_0, 2'b00};   // branch
         7'b0010011: c = {12'b1_000_1_0_00_0_10_0, 2'b00};   // I-ALU
         7'b1101111: c = {12'b1_011_0_0_10_0_10_1, 2'b00};   // JAL
         7'b1100111: c = {12'b1_000_1_0_10_0_00_1, 2'b00};   // JALR
         7'b0110111: c = {12'b1_100_1_0_00_0_11_0, 2'b00};   // LUI
         7'b0010111: c = {12'b1_100_1_0_11_0_00_0, 2'b00};   // AUIPC
         7'b0110011: begin                                    // R-type
            if (ins[31:25] == 7'b0000000 || ins[31:25] == 7'b0100000)
               c = {12'b1_000_0_0_00_0_10_0, 2'b00};
`ifdef CONTROL_DECODE_MULDIV_EN
            else if (ins[31:25] == 7'b0000001)
               c = {12'b1_000_0_0_00_0_10_0, 2'b10};
`endif
            else
               c = CTRL_ILLEGAL;
         end
         default: c = CTRL_ILLEGAL;
      endcase
      return c;
   endfunction

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [ILLEGAL_CNT_WIDTH-1:0] sat_inc(
      input logic [ILLEGAL_CNT_WIDTH-1:0] v
   );
      if (&v)
         return v;
      return v + ILLEGAL_CNT_WIDTH'(1);
   endfunction

   state_t                         state_q, state_d;
   ctrl_t                          ctrl_p0;
   ctrl_t                          ctrl_p1;
   logic [4:0]                     rd_p1;
   logic [ILLEGAL_CNT_WIDTH-1:0]   ill_cnt_q;
   logic                           accept;
   logic                           unused_bits;

`ifdef CONTROL_DECODE_MULDIV_EN
   localparam logic [3:0] CNT_INIT = 4'(MULDIV_LATENCY - 1);
   logic [3:0] cnt_q, cnt_d;
`else
   localparam int unused_latency = MULDIV_LATENCY;
`endif

   // ---- stage p0: combinational decode of the incoming instruction ----
   assign ctrl_p0 = decode(instr_i[31:0]);
   assign accept  = valid_i && ready_o;

   // Accept when empty, or when the held entry is leaving this cycle.
   always_comb begin
      ready_o = 1'b0;
      if (!rst_i && !flush_i)
         ready_o = (state_q == EMPTY) || ((state_q == FULL) && ready_i);
   end

   // Next-state logic; flush overrides everything, accept overrides drain.
   always_comb begin
      state_d = state_q;
`ifdef CONTROL_DECODE_MULDIV_EN
      cnt_d   = cnt_q;
`endif
      if (flush_i) begin
         state_d = EMPTY;
`ifdef CONTROL_DECODE_MULDIV_EN
         cnt_d   = '0;
`endif
      end else begin
         case (state_q)
            EMPTY: state_d = EMPTY;
            FULL:  if (ready_i) state_d = EMPTY;
`ifdef CONTROL_DECODE_MULDIV_EN
            MD_BUSY: begin
               if (cnt_q == 4'd0)
                  state_d = FULL;
               else
                  cnt_d = cnt_q - 4'd1;
            end
`endif
            default: state_d = EMPTY;
         endcase
         if (accept) begin
            state_d = FULL;
`ifdef CONTROL_DECODE_MULDIV_EN
            if (ctrl_p0.muldiv) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_INIT;
            end
`endif
         end
      end
   end

   // State register (and M-extension busy counter when built).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
`ifdef CONTROL_DECODE_MULDIV_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef CONTROL_DECODE_MULDIV_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // ---- stage p1: decoded controls registered at accept ----
   // Output register loads only on accept so outputs stay stable under backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_p1 <= '0;
         rd_p1   <= '0;
      end else if (accept) begin
         ctrl_p1 <= ctrl_p0;
         rd_p1   <= instr_i[11:7];
      end
   end

   // Illegal-instruction counter: counts accepted illegals, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         ill_cnt_q <= '0;
      else if (accept && ctrl_p0.illegal)
         ill_cnt_q <= sat_inc(ill_cnt_q);
   end

   assign valid_o       = (state_q == FULL);
   assign reg_write_o   = ctrl_p1.reg_write;
   assign imm_src_o     = ctrl_p1.imm_src;
   assign alu_src_o     = ctrl_p1.alu_src;
   assign mem_write_o   = ctrl_p1.mem_write;
   assign result_src_o  = ctrl_p1.result_src;
   assign branch_o      = ctrl_p1.branch;
   assign alu_op_o      = ctrl_p1.alu_op;
   assign jump_o        = ctrl_p1.jump;
   assign illegal_o     = ctrl_p1.illegal;
   assign rd_o          = rd_p1;
   assign illegal_cnt_o = ill_cnt_q;

`ifdef CONTROL_DECODE_MULDIV_EN
   assign muldiv_o    = ctrl_p1.muldiv;
   assign unused_bits = ^instr_i[24:12];
`else
   // Without the M-extension the muldiv bit is never set; tie the port off.
   assign muldiv_o    = 1'b0;
   assign unused_bits = ^{instr_i[24:12], ctrl_p1.muldiv};
`endif

endmodule

// File: tb/tb_control_decode_stage.sv
// tb_control_decode_stage: directed test-plan sequences plus randomized traffic,
// every cycle compared against a table-driven behavioural model of the stage.
module tb_control_decode_stage;

   localparam int LAT  = 4;
   localparam int CW   = 8;
   localparam int MAXC = (1 << CW) - 1;

   localparam logic [31:0] I_LW    = 32'h00002083;
   localparam logic [31:0] I_SW    = 32'h00112023;
   localparam logic [31:0] I_BEQ   = 32'h00208063;
   localparam logic [31:0] I_JALR  = 32'h000080E7;
   localparam logic [31:0] I_ADDI  = 32'h00508093;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_MUL   = 32'h021080B3;
   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_BAD   = 32'h0000007F;

   logic          clk = 1'b0;
   logic          rst_i, valid_i, ready_i, flush_i;
   logic [31:0]   instr_i;
   logic          ready_o, valid_o, branch_o, jump_o, mem_write_o, alu_src_o, reg_write_o;
   logic [1:0]    result_src_o, alu_op_o;
   logic [2:0]    imm_src_o;
   logic [4:0]    rd_o;
   logic          muldiv_o, illegal_o;
   logic [CW-1:0] illegal_cnt_o;

   always #5 clk = ~clk;

   control_decode_stage #(
      .INSTR_WIDTH(32), .MULDIV_LATENCY(LAT), .ILLEGAL_CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .valid_i(valid_i),
      .ready_o(ready_o), .ready_i(ready_i), .flush_i(flush_i), .valid_o(valid_o),
      .branch_o(branch_o), .jump_o(jump_o), .mem_write_o(mem_write_o),
      .alu_src_o(alu_src_o), .reg_write_o(reg_write_o), .result_src_o(result_src_o),
      .imm_src_o(imm_src_o), .alu_op_o(alu_op_o), .rd_o(rd_o), .muldiv_o(muldiv_o),
      .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Decode table rows: reg_write,imm_src,alu_src,mem_write,result_src,branch,alu_op,jump
   logic [6:0]  tbl_op  [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
   logic [11:0] tbl_row [9] = '{12'b1_000_1_0_01_0_00_0, 12'b0_001_1_1_00_0_00_0,
                                12'b1_000_0_0_00_0_10_0, 12'b0_010_0_0_00_1_01_0,
                                12'b1_000_1_0_00_0_10_0, 12'b1_011_0_0_10_0_10_1,
                                12'b1_000_1_0_10_0_00_1, 12'b1_100_1_0_00_0_11_0,
                                12'b1_100_1_0_11_0_00_0};

   // Model decode: {controls[11:0], muldiv, illegal}
   function automatic logic [13:0] exp_decode(input logic [31:0] ins);
      logic [6:0] f7;
      bit md_ok;
      f7 = ins[31:25];
`ifdef CONTROL_DECODE_MULDIV_EN
      md_ok = 1'b1;
`else
      md_ok = 1'b0;
`endif
      for (int i = 0; i < 9; i++) begin
         if (ins[6:0] == tbl_op[i]) begin
            if (ins[6:0] != 7'b0110011) return {tbl_row[i], 2'b00};
            if (f7 == 7'h00 || f7 == 7'h20) return {tbl_row[i], 2'b00};
            if (f7 == 7'h01 && md_ok) return {tbl_row[i], 2'b10};
            return 14'd1;
         end
      end
      return 14'd1;
   endfunction

   // Model state: what the execute stage should see.
   bit          m_valid;
   int          m_busy;
   logic [13:0] m_ctrl;
   logic [4:0]  m_rd;
   int          m_cnt;

   task automatic model_reset();
      m_valid = 0; m_busy = 0; m_ctrl = '0; m_rd = '0; m_cnt = 0;
   endtask

   // One clock: drive at negedge, compare, then advance the model at the posedge.
   task automatic step(input logic r, input logic v, input logic rdy, input logic fl,
                       input logic [31:0] ins);
      logic        exp_ready, acc;
      logic [13:0] d;
      logic [11:0] dut_ctrl;
      @(negedge clk);
      rst_i = r; valid_i = v; ready_i = rdy; flush_i = fl; instr_i = ins;
      #1;
      exp_ready = !r && !fl && ((!m_valid && m_busy == 0) || (m_valid && rdy));
      dut_ctrl  = {reg_write_o, imm_src_o, alu_src_o, mem_write_o, result_src_o,
                   branch_o, alu_op_o, jump_o};
      chk("ready_o",       32'(ready_o),       32'(exp_ready));
      chk("valid_o",       32'(valid_o),       32'(m_valid));
      chk("controls",      32'(dut_ctrl),      32'(m_ctrl[13:2]));
      chk("muldiv_o",      32'(muldiv_o),      32'(m_ctrl[1]));
      chk("illegal_o",     32'(illegal_o),     32'(m_ctrl[0]));
      chk("rd_o",          32'(rd_o),          32'(m_rd));
      chk("illegal_cnt_o", 32'(illegal_cnt_o), 32'(m_cnt));
      @(posedge clk);
      acc = v && exp_ready;
      if (r) begin
         model_reset();
      end else if (fl) begin
         m_valid = 0; m_busy = 0;
      end else begin
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_valid = 1;
         end else if (m_valid && rdy) begin
            m_valid = 0;
         end
         if (acc) begin
            d = exp_decode(ins);
            m_ctrl = d;
            m_rd   = ins[11:7];
            if (d[0] && m_cnt < MAXC) m_cnt++;
            if (d[1]) begin m_valid = 0; m_busy = LAT; end
            else m_valid = 1;
         end
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] x;
      int k;
      x = $urandom;
      k = $urandom_range(0, 11);
      if (k < 9) x[6:0] = tbl_op[k];
      if (x[6:0] == 7'b0110011) begin
         case ($urandom_range(0, 3))
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            2: x[31:25] = 7'h01;
            default: x[31:25] = 7'($urandom);
         endcase
      end
      return x;
   endfunction

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; instr_i = '0;
      @(posedge clk);
      model_reset();

      // Reset held with valid_i asserted
      step(1, 1, 1, 0, I_LW);
      step(1, 1, 1, 0, I_LW);
      step(0, 0, 1, 0, '0);

      // Back-to-back decode
      step(0, 1, 1, 0, I_LW);
      #1 chk("lw_result_src", 32'(result_src_o), 32'd1);
      step(0, 1, 1, 0, I_SW);
      #1 chk("sw_mem_write", 32'(mem_write_o), 32'd1);
      step(0, 1, 1, 0, I_BEQ);
      #1 chk("beq_branch", 32'(branch_o), 32'd1);
      step(0, 1, 1, 0, I_JALR);
      #1 chk("jalr_jump_rs", 32'({jump_o, result_src_o}), 32'b110);
      step(0, 0, 1, 0, '0);

      // Backpressure: addi held while lui waits
      step(0, 1, 1, 0, I_ADDI);
      step(0, 1, 0, 0, I_LUI);
      step(0, 1, 0, 0, I_LUI);
      step(0, 1, 1, 0, I_LUI);
      #1 chk("lui_alu_op", 32'(alu_op_o), 32'd3);
      step(0, 0, 1, 0, '0);

      // Illegal count and saturation
      step(1, 0, 1, 0, '0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, I_BAD);
      #1 chk("ill_cnt_3", 32'(illegal_cnt_o), 32'd3);
      chk("ill_noop", 32'({reg_write_o, mem_write_o, illegal_o}), 32'b001);
      for (int i = 0; i < 257; i++) step(0, 1, 1, 0, I_BAD);
      #1 chk("ill_cnt_sat", 32'(illegal_cnt_o), 32'(MAXC));

      // M-extension op
      step(1, 0, 1, 0, '0);
      step(0, 0, 1, 0, '0);
      step(0, 1, 1, 0, I_MUL);
`ifdef CONTROL_DECODE_MULDIV_EN
      for (int i = 0; i < LAT - 1; i++) step(0, 1, 1, 0, I_ADD);
      #1 chk("md_not_yet", 32'(valid_o), 32'd0);
      step(0, 1, 1, 0, I_ADD);
      #1 chk("md_done", 32'({valid_o, muldiv_o}), 32'b11);
`else
      #1 chk("mul_illegal", 32'({valid_o, illegal_o}), 32'b11);
`endif
      step(0, 0, 1, 0, '0);

      // Flush during busy
      step(0, 1, 1, 0, I_MUL);
      step(0, 0, 1, 0, '0);
      step(0, 1, 1, 1, I_ADD);
      #1 chk("flush_valid", 32'(valid_o), 32'd0);
      step(0, 0, 1, 0, '0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), rand_instr());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
